// File: rtl/fcp_credit_responder.sv
// fcp_credit_responder
//
// Receiver model that closes the traffic injector's credit loop. Packets from
// the injector are counted per VC in a table of {rx_cnt, drain_cnt}. Arrived
// VCs are queued in a drain FIFO. A periodic drain timer pops one VC at a time
// to model the receiver's buffer emptying. Every arrival and every drain
// produces one Flow Control Packet message carrying fccl/qlen/fccr for that VC.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   s_axis_pkt_*         packet stream input; the first beat carries the VC in
//                        tdata[QUEUE_INDEX_WIDTH-1:0]; tkeep is ignored
//   s_axis_pkt_tready    init_done & !fifo_full
//   drain_enable         gates drain opportunities
//   fcp_valid            one-cycle message strobe
//   fcp_vc               VC of the message
//   fcp_fccl             drain_cnt + CREDIT_LIMIT
//   fcp_qlen             rx_cnt - drain_cnt
//   fcp_fccr             rx_cnt
//   rx_pkt_count         total accepted packets
//   init_done            table clear sweep complete
//   fifo_full            drain FIFO full
module fcp_credit_responder #(
  parameter int QUEUE_INDEX_WIDTH = 16,
  parameter int DATA_WIDTH        = 512,
  parameter int CREDIT_LIMIT      = 64,
  parameter int FIFO_ADDR_WIDTH   = 10,
  parameter int DRAIN_INTERVAL    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_pkt_tdata,
  input  logic                         s_axis_pkt_tvalid,
  input  logic                         s_axis_pkt_tlast,
  input  logic [DATA_WIDTH/8-1:0]      s_axis_pkt_tkeep,
  output logic                         s_axis_pkt_tready,
  input  logic                         drain_enable,
  output logic                         fcp_valid,
  output logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  output logic [31:0]                  fcp_fccl,
  output logic [31:0]                  fcp_qlen,
  output logic [31:0]                  fcp_fccr,
  output logic [63:0]                  rx_pkt_count,
  output logic                         init_done,
  output logic                         fifo_full
);

  localparam int TABLE_DEPTH = 1 << QUEUE_INDEX_WIDTH;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_WIDTH;
  localparam int CNT_W       = FIFO_ADDR_WIDTH + 1;
  localparam int TIMER_W     = $clog2(DRAIN_INTERVAL);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DRAIN_INTERVAL - 1);
  localparam logic [CNT_W-1:0]   FIFO_FULL_COUNT = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [31:0]        CREDIT_LIMIT_W  = 32'(CREDIT_LIMIT);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // Table entry: {rx_cnt[31:0], drain_cnt[31:0]}
  logic [63:0]                  table_mem [TABLE_DEPTH];
  logic [QUEUE_INDEX_WIDTH-1:0] fifo_mem  [FIFO_DEPTH];

  state_t                       state_r;
  logic [QUEUE_INDEX_WIDTH-1:0] init_addr_r;
  logic                         init_done_r;

  logic                         sop_r;
  logic [QUEUE_INDEX_WIDTH-1:0] vc_r;
  logic [63:0]                  rx_pkt_count_r;

  logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr_r;
  logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]             fifo_count_r;
  logic [CNT_W-1:0]             fifo_count_next_s;
  logic                         fifo_full_r;

  logic [TIMER_W-1:0]           timer_r;
  logic                         drain_pending_r;
  logic [QUEUE_INDEX_WIDTH-1:0] drain_vc_r;

  logic                         s1_valid_r;
  logic                         s1_drain_r;
  logic [QUEUE_INDEX_WIDTH-1:0] s1_vc_r;
  logic                         fwd_r;
  logic [63:0]                  fwd_data_r;
  logic [63:0]                  tbl_rd_r;
  logic [63:0]                  s1_entry_s;
  logic [63:0]                  s1_upd_s;

  logic                         fcp_valid_r;
  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc_r;
  logic [31:0]                  fcp_fccl_r;
  logic [31:0]                  fcp_qlen_r;
  logic [31:0]                  fcp_fccr_r;

  logic                         tready_s;
  logic                         accept_s;
  logic                         arrive_s;
  logic [QUEUE_INDEX_WIDTH-1:0] cur_vc_s;
  logic                         timer_wrap_s;
  logic                         pop_s;
  logic                         drain_issue_s;
  logic                         op_valid_s;
  logic                         op_drain_s;
  logic [QUEUE_INDEX_WIDTH-1:0] op_vc_s;
  logic                         fwd_s;
  logic                         tbl_we_s;
  logic [QUEUE_INDEX_WIDTH-1:0] tbl_waddr_s;
  logic [63:0]                  tbl_wdata_s;
  logic                         unused_s;

  // tkeep and payload bits above the VC field carry no meaning for this model
  assign unused_s = ^{s_axis_pkt_tkeep, s_axis_pkt_tdata[DATA_WIDTH-1:QUEUE_INDEX_WIDTH]};

  assign tready_s          = init_done_r & ~fifo_full_r;
  assign s_axis_pkt_tready = tready_s;
  assign accept_s          = s_axis_pkt_tvalid & tready_s;
  assign arrive_s          = accept_s & s_axis_pkt_tlast;
  // A single-beat packet has no captured VC yet, so take it straight from tdata
  assign cur_vc_s          = sop_r ? s_axis_pkt_tdata[QUEUE_INDEX_WIDTH-1:0] : vc_r;

  assign timer_wrap_s  = (timer_r == TIMER_LAST);
  assign pop_s         = timer_wrap_s & drain_enable & (fifo_count_r != '0) & ~drain_pending_r;
  // Arrivals always win; a pending drain waits for the first idle slot
  assign drain_issue_s = drain_pending_r & ~arrive_s;
  assign op_valid_s    = arrive_s | drain_issue_s;
  assign op_drain_s    = ~arrive_s;
  assign op_vc_s       = arrive_s ? cur_vc_s : drain_vc_r;
  // Back-to-back ops to one VC: the RAM has not yet seen stage 1's write
  assign fwd_s         = s1_valid_r & op_valid_s & (op_vc_s == s1_vc_r);

  assign fcp_valid    = fcp_valid_r;
  assign fcp_vc       = fcp_vc_r;
  assign fcp_fccl     = fcp_fccl_r;
  assign fcp_qlen     = fcp_qlen_r;
  assign fcp_fccr     = fcp_fccr_r;
  assign rx_pkt_count = rx_pkt_count_r;
  assign init_done    = init_done_r;
  assign fifo_full    = fifo_full_r;

  // INIT sweeps the table to zero one entry per cycle, then RUN forever
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      init_addr_r <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_addr_r == '1) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            init_addr_r <= init_addr_r + QUEUE_INDEX_WIDTH'(1);
          end
        end
        ST_RUN: begin
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          init_addr_r <= '0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Start-of-packet tracking and total packet counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sop_r          <= 1'b1;
      vc_r           <= '0;
      rx_pkt_count_r <= 64'd0;
    end else begin
      if (accept_s) begin
        sop_r <= s_axis_pkt_tlast;
        if (sop_r) begin
          vc_r <= s_axis_pkt_tdata[QUEUE_INDEX_WIDTH-1:0];
        end
      end
      if (arrive_s) begin
        rx_pkt_count_r <= rx_pkt_count_r + 64'd1;
      end
    end
  end

  // Drain FIFO occupancy after this cycle's push and pop
  always_comb begin
    fifo_count_next_s = fifo_count_r;
    case ({arrive_s, pop_s})
      2'b10:   fifo_count_next_s = fifo_count_r + CNT_W'(1);
      2'b01:   fifo_count_next_s = fifo_count_r - CNT_W'(1);
      default: fifo_count_next_s = fifo_count_r;
    endcase
  end

  // Drain FIFO storage
  always_ff @(posedge clk) begin
    if (arrive_s) begin
      fifo_mem[wr_ptr_r] <= cur_vc_s;
    end
  end

  // Drain FIFO pointers, full flag, drain timer and pending drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      fifo_count_r    <= '0;
      fifo_full_r     <= 1'b0;
      timer_r         <= '0;
      drain_pending_r <= 1'b0;
      drain_vc_r      <= '0;
    end else begin
      if (arrive_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_ADDR_WIDTH'(1);
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + FIFO_ADDR_WIDTH'(1);
        drain_vc_r <= fifo_mem[rd_ptr_r];
      end
      fifo_count_r <= fifo_count_next_s;
      fifo_full_r  <= (fifo_count_next_s == FIFO_FULL_COUNT);
      if (timer_wrap_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TIMER_W'(1);
      end
      if (pop_s) begin
        drain_pending_r <= 1'b1;
      end else if (drain_issue_s) begin
        drain_pending_r <= 1'b0;
      end
    end
  end

  // Stage 1 entry selection and counter update
  always_comb begin
    s1_entry_s = fwd_r ? fwd_data_r : tbl_rd_r;
    if (s1_drain_r) begin
      s1_upd_s = {s1_entry_s[63:32], s1_entry_s[31:0] + 32'd1};
    end else begin
      s1_upd_s = {s1_entry_s[63:32] + 32'd1, s1_entry_s[31:0]};
    end
  end

  // Single table write port: init sweep owns it until RUN, then stage 1
  always_comb begin
    tbl_we_s    = 1'b0;
    tbl_waddr_s = s1_vc_r;
    tbl_wdata_s = s1_upd_s;
    if (state_r == ST_INIT) begin
      tbl_we_s    = 1'b1;
      tbl_waddr_s = init_addr_r;
      tbl_wdata_s = 64'd0;
    end else begin
      tbl_we_s    = s1_valid_r;
    end
  end

  // Table RAM: registered read at stage 0, write-back from stage 1
  always_ff @(posedge clk) begin
    tbl_rd_r <= table_mem[op_vc_s];
    if (tbl_we_s) begin
      table_mem[tbl_waddr_s] <= tbl_wdata_s;
    end
  end

  // Stage 0 -> stage 1 op registers and forwarding capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_drain_r <= 1'b0;
      s1_vc_r    <= '0;
      fwd_r      <= 1'b0;
      fwd_data_r <= 64'd0;
    end else begin
      s1_valid_r <= op_valid_s;
      s1_drain_r <= op_drain_s;
      s1_vc_r    <= op_vc_s;
      fwd_r      <= fwd_s;
      fwd_data_r <= s1_upd_s;
    end
  end

  // FCP message registers, loaded from the updated entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcp_valid_r <= 1'b0;
      fcp_vc_r    <= '0;
      fcp_fccl_r  <= 32'd0;
      fcp_qlen_r  <= 32'd0;
      fcp_fccr_r  <= 32'd0;
    end else begin
      fcp_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        fcp_vc_r   <= s1_vc_r;
        fcp_fccl_r <= s1_upd_s[31:0] + CREDIT_LIMIT_W;
        fcp_qlen_r <= s1_upd_s[63:32] - s1_upd_s[31:0];
        fcp_fccr_r <= s1_upd_s[63:32];
      end
    end
  end

endmodule
